// File: rtl/quant_pkg.sv
// quant_pkg: requantization constants and scheduler FSM state type
package quant_pkg;
  localparam longint Q = 2014687024;
  localparam int SHIFT = 31;
  localparam int EXPONENT = 8;
  localparam int MASK = 255;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
endpackage

// File: rtl/quant_core.sv
// quant_core: LAT-stage requantization pipeline; QUANT_SATURATE_EN clamps the result to [-256, 255]
module quant_core
  import quant_pkg::*;
#(
  parameter int LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic signed [63:0] in_data,
  output logic              out_valid,
  output logic signed [8:0] out_data
);
  logic signed [95:0] prod, x, y;
  logic [7:0] rem, thr;
  logic rnd;
  logic signed [8:0] q;
  logic [LAT-1:0] vld;
  logic signed [8:0] dat [LAT];
  // scale, round half away from zero on the dropped byte, then narrow to 9 bits
  always_comb begin
    prod = 96'(in_data) * 96'(Q);
    x = prod >>> SHIFT;
    rem = 8'(x & 96'(MASK));
    thr = 8'd127 + {7'd0, x[95]};
    rnd = rem > thr;
    y = (x >>> EXPONENT) + $signed({95'd0, rnd});
`ifdef QUANT_SATURATE_EN
    q = y > 96'sd255 ? 9'h0ff : y < -96'sd256 ? 9'h100 : 9'(y);
`else
    q = 9'(y);
`endif
  end
  // carry the result and its valid flag through the remaining delay stages
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) dat[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      dat[0] <= q;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  assign out_valid = vld[LAT-1];
  assign out_data = dat[LAT-1];
endmodule

// File: rtl/quant_scheduler.sv
// quant_scheduler: round-robin sharing of one requantization engine; QUANT_SATURATE_EN selects clamped output
module quant_scheduler
  import quant_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LAT = 4,
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1,
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [64*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 out_valid,
  output logic signed [8:0]    out_data,
  output logic [IW-1:0]        out_id,
  input  logic                 out_ready
);
  state_t state, nxt;
  logic [IW-1:0] ptr, grant, pick;
  logic found;
  logic [CW-1:0] cnt;
  logic core_valid;
  logic signed [8:0] core_data;
  // first valid requester at or after the round-robin pointer
  always_comb begin
    pick = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      if (!found && req_valid[(int'(ptr) + i) % N_REQ]) begin
        found = 1'b1;
        pick = IW'((int'(ptr) + i) % N_REQ);
      end
  end
  // next state and handshake outputs
  always_comb begin
    nxt = state;
    req_ready = '0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: nxt = found ? ISSUE : IDLE;
      ISSUE: begin
        nxt = WAIT;
        req_ready = N_REQ'(1) << grant;
      end
      WAIT: nxt = cnt == CW'(LAT-1) ? HOLD : WAIT;
      HOLD: begin
        nxt = out_ready ? IDLE : HOLD;
        out_valid = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end
  // state, grant bookkeeping, latency counter and held result
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      grant <= '0;
      cnt <= '0;
      out_data <= '0;
      out_id <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && found) begin
        grant <= pick;
        ptr <= pick == IW'(N_REQ-1) ? '0 : pick + 1'b1;
      end
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (core_valid) begin
        out_data <= core_data;
        out_id <= grant;
      end
    end
  quant_core #(.LAT(LAT)) core (
    .clk(clk),
    .rst(rst),
    .in_valid(state == ISSUE),
    .in_data($signed(req_data[64*int'(grant) +: 64])),
    .out_valid(core_valid),
    .out_data(core_data)
  );
endmodule

// File: tb/tb_quant_scheduler.sv
// tb_quant_scheduler: directed checks of arbitration, latency, hold, arithmetic and reset
module tb_quant_scheduler;
  localparam int N = 4;
  localparam int L = 4;
`ifdef QUANT_SATURATE_EN
  localparam logic signed [8:0] BIG = 9'sd255;
`else
  localparam logic signed [8:0] BIG = 9'sd75;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_ready = 1'b0;
  logic out_valid;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [64*N-1:0] req_data = '0;
  logic signed [8:0] out_data;
  logic [1:0] out_id;
  int checks = 0;
  int fails = 0;
  int hits;
  int ids [5] = '{0, 1, 2, 3, 0};
  logic signed [8:0] exps [5];
  always #5 clk = ~clk;
  quant_scheduler #(.N_REQ(N), .LAT(L)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_id(out_id),
    .out_ready(out_ready)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_out(input logic clr, output int cyc, output logic [3:0] seen);
    cyc = 0;
    seen = '0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
      if (req_ready != '0 && seen == '0) begin
        seen = req_ready;
        if (clr) req_valid &= ~req_ready;
      end
    end
  endtask
  task automatic serve(input string tag, input logic clr, input int id, input logic signed [8:0] d);
    int cyc;
    logic [3:0] seen;
    wait_out(clr, cyc, seen);
    check({tag, " latency"}, 64'(cyc), 64'(L + 2));
    check({tag, " ready"}, 64'(seen), 64'(1) << id);
    check({tag, " id"}, 64'(out_id), 64'(id));
    check({tag, " data"}, 64'(out_data), 64'(d));
  endtask
  initial begin
    exps = '{9'sd1, 9'sd4, -9'sd1, BIG, 9'sd1};
    #1 rst = 1'b0;
    repeat (2) tick();
    check("reset out_valid", 64'(out_valid), 64'(0));
    check("reset req_ready", 64'(req_ready), 64'(0));
    check("reset out_data", 64'(out_data), 64'(0));
    check("reset out_id", 64'(out_id), 64'(0));
    rst = 1'b1;
    tick();
    req_data[63:0] = 64'd256;
    req_valid = 4'b0001;
    out_ready = 1'b1;
    serve("single", 1'b1, 0, 9'sd1);
    tick();
    check("single one-cycle valid", 64'(out_valid), 64'(0));
    req_data[127:64] = 64'd1000;
    req_data[255:192] = 64'd0;
    req_valid = 4'b1010;
    serve("pair first", 1'b1, 1, 9'sd4);
    tick();
    serve("pair second", 1'b1, 3, 9'sd0);
    tick();
    req_data[63:0] = 64'd256;
    req_data[127:64] = 64'd1000;
    req_data[191:128] = -64'sd256;
    req_data[255:192] = 64'd300000;
    req_valid = 4'hf;
    for (int i = 0; i < 5; i++) begin
      serve($sformatf("rr%0d", i), 1'b0, ids[i], exps[i]);
      if (i == 4) req_valid = '0;
      tick();
    end
    req_data[127:64] = 64'd300000;
    req_valid = 4'b0010;
    out_ready = 1'b0;
    serve("hold", 1'b1, 1, BIG);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold valid %0d", i), 64'(out_valid), 64'(1));
      check($sformatf("hold data %0d", i), 64'(out_data), 64'(BIG));
    end
    out_ready = 1'b1;
    tick();
    check("hold release", 64'(out_valid), 64'(0));
    req_data[191:128] = 64'd1000;
    req_valid = 4'b0100;
    tick();
    check("abort issue ready", 64'(req_ready), 64'(4'b0100));
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check("abort out_valid", 64'(out_valid), 64'(0));
    check("abort req_ready", 64'(req_ready), 64'(0));
    check("abort out_data", 64'(out_data), 64'(0));
    check("abort out_id", 64'(out_id), 64'(0));
    tick();
    rst = 1'b1;
    hits = 0;
    repeat (12) begin
      tick();
      if (out_valid) hits++;
    end
    check("no stray valid", 64'(hits), 64'(0));
    req_valid = 4'b1100;
    serve("post reset", 1'b1, 2, 9'sd4);
    tick();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
